// File: rtl/nibble_serial_adder.sv
// Multi-word adder that walks two WIDTH-bit operands through one 4-bit ripple slice, one nibble per cycle.
// Optional feature macro: SUBTRACT_EN adds a 'sub' input that turns the operation into op_a - op_b.

module nibble_adder_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [1:0]       fsm_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid depend only on state (and rst), never on in_valid or out_ready.

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_next;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [3:0]        nib_s;
    logic              nib_co;
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;

`ifdef SUBTRACT_EN
    // Two's-complement subtract: invert B and force a carry-in of one.
    assign b_load     = sub ? ~op_b : op_b;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = op_b;
    assign carry_load = c_in;
`endif

    nibble_adder_slice u_slice (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    // Each result nibble enters at the top, so after NIB shifts the sum is in place.
    if (NIB == 1) begin : g_sum_one
        assign sum_next = nib_s;
    end else begin : g_sum_many
        assign sum_next = {nib_s, sum_q[WIDTH-1:4]};
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    sum_q   <= sum_next;
                    carry_q <= nib_co;
                    cnt_q   <= cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = sum_q;
    assign c_out     = carry_q;
    assign fsm_state = state_q;
endmodule
